// File: rtl/fir_s2p_buffer.sv
// rtl/fir_s2p_buffer.sv - ping-pong serial-to-parallel frame buffer between FIR and 16-point FFT
module fir_s2p_buffer #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fir_valid,
  input  logic [DATA_W-1:0] fir_d,
  input  logic              s2p_ready,
  output logic              s2p_valid,
  output logic [DATA_W-1:0] s2p_d0,
  output logic [DATA_W-1:0] s2p_d1,
  output logic [DATA_W-1:0] s2p_d2,
  output logic [DATA_W-1:0] s2p_d3,
  output logic [DATA_W-1:0] s2p_d4,
  output logic [DATA_W-1:0] s2p_d5,
  output logic [DATA_W-1:0] s2p_d6,
  output logic [DATA_W-1:0] s2p_d7,
  output logic [DATA_W-1:0] s2p_d8,
  output logic [DATA_W-1:0] s2p_d9,
  output logic [DATA_W-1:0] s2p_d10,
  output logic [DATA_W-1:0] s2p_d11,
  output logic [DATA_W-1:0] s2p_d12,
  output logic [DATA_W-1:0] s2p_d13,
  output logic [DATA_W-1:0] s2p_d14,
  output logic [DATA_W-1:0] s2p_d15,
  output logic              overflow
);

  // Read-side state is the full flag of the bank being presented.
  localparam logic [0:0] ST_EMPTY   = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  logic [DATA_W-1:0] bank_q [2][16];
  logic [3:0]        wr_cnt_q, wr_cnt_d;
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic [1:0]        full_q, full_d;
  logic              overflow_q, overflow_d;
  logic [0:0]        rd_state;

  logic wr_en;
  logic wr_last;
  logic drop;
  logic xfer;

  // Fullness is judged on registered flags, so a bank freed this edge is not yet writable.
  always_comb begin
    wr_en    = fir_valid & ~full_q[wr_sel_q];
    drop     = fir_valid &  full_q[wr_sel_q];
    wr_last  = wr_en & (wr_cnt_q == 4'd15);
    rd_state = full_q[rd_sel_q] ? ST_PRESENT : ST_EMPTY;
    xfer     = (rd_state == ST_PRESENT) & s2p_ready;
  end

  // Next-state: write pointer, bank selects, full flags and sticky overflow.
  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    full_d     = full_q;
    overflow_d = overflow_q | drop;
    if (!fir_valid) begin
      // A stream break discards the partial frame; completed banks are untouched.
      wr_cnt_d = 4'd0;
    end else if (wr_en) begin
      if (wr_last) begin
        wr_cnt_d = 4'd0;
        wr_sel_d = ~wr_sel_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 4'd1;
      end
    end
    if (xfer) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
    // wr_last and xfer never target the same bank: one needs it empty, the other full.
    if (wr_last) begin
      full_d[wr_sel_q] = 1'b1;
    end
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q   <= 4'd0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      full_q     <= 2'b00;
      overflow_q <= 1'b0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  // Frame storage; samples are stored bit-exact at the current write slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < 16; k++) begin
          bank_q[b][k] <= '0;
        end
      end
    end else if (wr_en) begin
      bank_q[wr_sel_q][wr_cnt_q] <= fir_d;
    end
  end

  assign s2p_valid = (rd_state == ST_PRESENT);
  assign overflow  = overflow_q;

  assign s2p_d0  = bank_q[rd_sel_q][0];
  assign s2p_d1  = bank_q[rd_sel_q][1];
  assign s2p_d2  = bank_q[rd_sel_q][2];
  assign s2p_d3  = bank_q[rd_sel_q][3];
  assign s2p_d4  = bank_q[rd_sel_q][4];
  assign s2p_d5  = bank_q[rd_sel_q][5];
  assign s2p_d6  = bank_q[rd_sel_q][6];
  assign s2p_d7  = bank_q[rd_sel_q][7];
  assign s2p_d8  = bank_q[rd_sel_q][8];
  assign s2p_d9  = bank_q[rd_sel_q][9];
  assign s2p_d10 = bank_q[rd_sel_q][10];
  assign s2p_d11 = bank_q[rd_sel_q][11];
  assign s2p_d12 = bank_q[rd_sel_q][12];
  assign s2p_d13 = bank_q[rd_sel_q][13];
  assign s2p_d14 = bank_q[rd_sel_q][14];
  assign s2p_d15 = bank_q[rd_sel_q][15];

endmodule

// File: doc/fir_s2p_buffer.md
Name: fir_s2p_buffer

Overview:
- Serial-to-parallel stage directly downstream of the FIR filter and upstream of the 16-point FFT.
- Collects 16 consecutive FIR output samples (`fir_d` qualified by `fir_valid`) into a ping-pong (two-bank) frame buffer.
- Presents each completed frame as 16 parallel words with a valid/ready handshake. The FFT can consume one frame while the next is being filled.

Parameters:
- DATA_W, 16, sample width in bits (signed, passed through unmodified).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- fir_valid  input  1  FIR output qualifier; high = `fir_d` holds a sample this cycle.
- fir_d  input  DATA_W  signed FIR output sample.
- s2p_ready  input  1  FFT accepts the presented frame when high together with `s2p_valid`.
- s2p_valid  output  1  a complete frame is presented on `s2p_d0..s2p_d15`.
- s2p_d0 .. s2p_d15  output  DATA_W each  frame words; `s2p_d0` = oldest (first-captured) sample, `s2p_d15` = newest.
- overflow  output  1  sticky; set when a sample is dropped because both banks are full.

Behaviour:
- Reset (async, `rst`=1):
  - Write counter `wr_cnt`=0; write bank `wr_sel`=0; read bank `rd_sel`=0.
  - Bank full flags `full[1:0]`=0; all bank storage =0.
  - Outputs: `s2p_valid`=0, `overflow`=0, `s2p_d0..d15`=0.
  - Reset mid-frame discards all partial and complete frames.
- Write side, evaluated each rising edge:
  - If `fir_valid`=1 and `full[wr_sel]`=0: `bank[wr_sel][wr_cnt]` <= `fir_d`.
    - If `wr_cnt`==15: `full[wr_sel]`<=1, `wr_sel` toggles, `wr_cnt`<=0.
    - Otherwise: `wr_cnt`<=`wr_cnt`+1.
  - If `fir_valid`=1 and `full[wr_sel]`=1 (both banks occupied): the sample is dropped, `wr_cnt` holds, `overflow`<=1 (sticky until reset).
  - If `fir_valid`=0: stream break. `wr_cnt`<=0, so any partial frame in the write bank is discarded. Full banks are untouched. The FIR restarts its own pipeline after `data_valid` drops, so partial frames must not mix across breaks.
- Read side (two-state FSM: EMPTY when `full[rd_sel]`=0, PRESENT when `full[rd_sel]`=1):
  - `s2p_valid` = `full[rd_sel]` (decoded from the register, no combinational path from `fir_*`).
  - `s2p_dk` = `bank[rd_sel][k]`. While EMPTY, outputs show stale bank contents, which are don't-care.
  - Transfer occurs on a rising edge with `s2p_valid`=1 and `s2p_ready`=1: `full[rd_sel]`<=0 and `rd_sel` toggles.
  - While `s2p_valid`=1 and `s2p_ready`=0, `s2p_d*` and `s2p_valid` hold stable.
- Latency: the edge that captures sample 15 sets `full`. `s2p_valid` is high in the following cycle, i.e. 1 cycle after the last sample is presented at the input.
- Frames are delivered strictly in capture order; `rd_sel` always points at the older full bank.
- Simultaneous events:
  - A transfer and a write in the same edge both take effect.
  - Write completion into the bank opposite `rd_sel` while `rd_sel` transfers: both flags update, and the new frame is presented the next cycle (back-to-back `s2p_valid`).
  - Fullness checks use the registered `full` flags. A sample arriving on the same edge that frees a bank is still dropped if `full[wr_sel]` was 1 before that edge.
- No arithmetic: data is stored bit-exact, with no sign change or rounding.

Test Plan:
- Reset, then 16 cycles of `fir_valid`=1 with `fir_d`=0x0001..0x0010, `s2p_ready`=1 → `s2p_valid` high exactly 1 cycle after the 16th sample; `s2p_d0`=0x0001, `s2p_d15`=0x0010; `s2p_valid` low the next cycle.
- Continuous stream of 48 samples (values 0..47) with `s2p_ready`=1 → three frames on successive banks 0,1,0; frame 2 has `s2p_d0`=16, `s2p_d15`=31; `overflow` stays 0.
- `s2p_ready`=0 throughout, 40 continuous samples → frames 0–15 and 16–31 fill both banks; samples 32..39 dropped; `overflow`=1; outputs hold 0..15 stable. Then `s2p_ready`=1 for 2 cycles → frame 0..15 accepted, then 16..31 presented.
- 10 samples (0x8000..0x8009, negative), `fir_valid` low 1 cycle, then 16 samples 0x0100..0x010F → only one frame emitted, `s2p_d0`=0x0100; the partial frame is discarded and negative values are never output.
- Assert `rst` asynchronously (mid-cycle) after 8 samples while one full frame is presented → `s2p_valid` and `overflow` drop to 0 immediately, without waiting for a clock edge; the next 16 samples form a fresh frame starting at `s2p_d0`.
- Back-to-back timing: `s2p_ready` deasserted until the second frame completes, then asserted → `s2p_valid` stays high for two consecutive transfer cycles with distinct frame data.
